wb_lsu_master: RTL and testbench
================================

WB_LSU_MASTER -- requirements
Module: wb_lsu_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the bus cycles waited for ack before abort (range 1..255).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port i_req_valid, input, 1, core load/store request valid.
REQ-005 SHALL have port o_req_ready, output, 1, block can accept a request.
REQ-006 SHALL have port i_req_we, input, 1; 1 = store, 0 = load.
REQ-007 SHALL have port i_req_addr, input, 32, byte address.
REQ-008 SHALL have port i_req_size, input, 2; 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-009 SHALL have port i_req_unsigned, input, 1; load zero-extends when 1, sign-extends when 0.
REQ-010 SHALL have port i_req_wdata, input, 32, store data, right-justified.
REQ-011 SHALL have port o_rsp_valid, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port o_rsp_rdata, output, 32, extended load data.
REQ-013 SHALL have port o_rsp_err, output, 1, misaligned, reserved size, or timeout.
REQ-014 SHALL have ports o_wb_cyc, o_wb_stb, o_wb_we, output, 1 each, Wishbone master controls.
REQ-015 SHALL have port o_wb_addr, output, 32, word-aligned address: {addr[31:2],2'b00}.
REQ-016 SHALL have port o_wb_sel, output, 4, byte-lane enables.
REQ-017 SHALL have port o_wb_data, output, 32, lane-aligned write data.
REQ-018 SHALL have port i_wb_data, input, 32, slave read data.
REQ-019 SHALL have port i_wb_ack, input, 1, slave acknowledge.

Function
REQ-020 SHALL implement FSM IDLE, BUS, RESP; o_req_ready = 1 only in IDLE.
REQ-021 SHALL accept a request on an edge where i_req_valid & o_req_ready, registering we, addr, size, unsigned and wdata.
REQ-022 SHALL set lanes by addr[1:0] (k): byte gives sel = 1<<k and wdata[7:0] on lane k; half at k=0 gives 0011, at k=2 gives 1100, with wdata[15:0] on that lane pair; word at k=0 gives 1111.
REQ-023 SHALL treat a half at odd k, a word at k!=0, or size 11 as an error: IDLE->RESP with no bus cycle, o_rsp_err=1, o_rsp_rdata=0.
REQ-024 SHALL, on an aligned accept, go IDLE->BUS and drive cyc=stb=1 plus addr, sel, we and data from registers, starting the cycle after accept.
REQ-025 SHALL hold all wb outputs stable in BUS until ack or timeout.
REQ-026 SHALL, on an edge in BUS with i_wb_ack=1, capture i_wb_data, deassert cyc/stb and go to RESP.
REQ-027 SHALL clear the wait counter on BUS entry and increment it each BUS cycle without ack.
REQ-028 SHALL, when the counter equals TIMEOUT with no ack, deassert cyc/stb, go to RESP, and set err=1 and rdata=0.
REQ-029 SHALL give ack priority over timeout in the same cycle.
REQ-030 SHALL pulse o_rsp_valid=1 for exactly one cycle in RESP, then return to IDLE.
REQ-031 SHALL NOT provide back-to-back issue: minimum initiation interval is 3 cycles (ack in first BUS cycle).
REQ-032 SHALL extract load data by shifting the captured word right 8*k, then sign- or zero-extend per size and unsigned; word loads pass unchanged; store rsp rdata=0.
REQ-033 SHALL ignore i_wb_ack outside BUS.
REQ-034 SHALL drive o_wb_we=0, sel=0 and data=0 whenever cyc=0.
REQ-035 SHALL leave o_rsp_rdata and o_rsp_err undefined-free: 0 when o_rsp_valid=0.

Reset
REQ-036 SHALL, with i_rst=1 at an edge, force IDLE and clear counter, cyc, stb, we, sel, addr, data, rsp_valid, rsp_rdata and rsp_err to 0.
REQ-037 SHALL, when reset occurs mid-BUS, drop cyc/stb at that edge and emit no response for the aborted request.
REQ-038 SHALL hold o_req_ready=0 during reset and set it to 1 on the first cycle after release.

Verification
REQ-039 SHALL verify a word load: addr=0x104, slave acks 2 cycles later with 0xDEADBEEF -> sel=1111, wb_addr=0x104, rsp_valid pulse, rdata=0xDEADBEEF, err=0.
REQ-040 SHALL verify a signed byte load at 0x103 with bus data 0x80xxxxxx -> sel=1000, rdata=0xFFFFFF80; the unsigned variant gives 0x00000080.
REQ-041 SHALL verify a half store of 0x1234 at 0x202 -> sel=1100, wb_data[31:16]=0x1234, we=1, rsp err=0.
REQ-042 SHALL verify a misaligned word at 0x101 -> cyc never asserted, rsp_valid the cycle after accept, err=1.
REQ-043 SHALL verify that with TIMEOUT=4 and no ack -> cyc high exactly 4 cycles, then rsp err=1, rdata=0, and o_req_ready returns to 1.
REQ-044 SHALL verify reset asserted in the 2nd BUS cycle -> cyc=0 next cycle, no rsp_valid, and a new request is accepted normally.

Source files
------------

// File: rtl/wb_lsu_master.sv
// Load/store unit that turns one core request into a single Wishbone classic cycle with lane steering and load extension.
// Latency: 3 cycles minimum (accept, one BUS cycle, RESP pulse); o_req_ready is high only in IDLE, so requests are never pipelined.
module wb_lsu_master #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_addr,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_data,
    input  logic [31:0] i_wb_data,
    input  logic        i_wb_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] wdat_q, wdat_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        req_misaligned;
    logic [3:0]  req_sel;
    logic [31:0] req_wdat;
    logic [31:0] rd_shift;
    logic [31:0] rd_ext;
    logic [8:0]  cnt_inc;
    logic        bus;

    // Lane steering is resolved at accept so the bus outputs come straight from flops.
    always_comb begin
        req_misaligned = 1'b0;
        req_sel        = 4'b0000;
        req_wdat       = 32'd0;
        case (i_req_size)
            2'b00: begin
                req_sel  = 4'b0001 << i_req_addr[1:0];
                req_wdat = {24'd0, i_req_wdata[7:0]} << {i_req_addr[1:0], 3'b000};
            end
            2'b01: begin
                req_misaligned = i_req_addr[0];
                req_sel        = i_req_addr[1] ? 4'b1100 : 4'b0011;
                req_wdat       = {16'd0, i_req_wdata[15:0]} << {i_req_addr[1], 4'b0000};
            end
            2'b10: begin
                req_misaligned = |i_req_addr[1:0];
                req_sel        = 4'b1111;
                req_wdat       = i_req_wdata;
            end
            default: req_misaligned = 1'b1;
        endcase
    end

    always_comb begin
        rd_shift = i_wb_data >> {addr_q[1:0], 3'b000};
        case (size_q)
            2'b00:   rd_ext = uns_q ? {24'd0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_ext = uns_q ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        cnt_inc = {1'b0, cnt_q} + 9'd1;
        case (state_q)
            S_IDLE: begin
                if (i_req_valid) begin
                    we_d    = i_req_we;
                    addr_d  = i_req_addr;
                    size_d  = i_req_size;
                    uns_d   = i_req_unsigned;
                    sel_d   = req_sel;
                    wdat_d  = req_wdat;
                    rdata_d = 32'd0;
                    cnt_d   = 8'd0;
                    err_d   = req_misaligned;
                    state_d = req_misaligned ? S_RESP : S_BUS;
                end
            end
            S_BUS: begin
                // Ack wins over a timeout landing in the same cycle.
                if (i_wb_ack) begin
                    rdata_d = we_q ? 32'd0 : rd_ext;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_inc[7:0];
                    if (cnt_inc == TIMEOUT_W) begin
                        rdata_d = 32'd0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            sel_q   <= 4'b0000;
            wdat_q  <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus         = (state_q == S_BUS);
    assign o_req_ready = (state_q == S_IDLE) && !i_rst;
    assign o_wb_cyc    = bus;
    assign o_wb_stb    = bus;
    assign o_wb_we     = bus && we_q;
    assign o_wb_addr   = bus ? {addr_q[31:2], 2'b00} : 32'd0;
    assign o_wb_sel    = bus ? sel_q : 4'b0000;
    assign o_wb_data   = bus ? wdat_q : 32'd0;
    assign o_rsp_valid = (state_q == S_RESP);
    assign o_rsp_rdata = o_rsp_valid ? rdata_q : 32'd0;
    assign o_rsp_err   = o_rsp_valid && err_q;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Scoreboard bench for wb_lsu_master: directed requests push expected responses, a monitor pops on o_rsp_valid.
module tb_wb_lsu_master;

    logic        i_clk;
    logic        i_rst;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [31:0] i_req_addr;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_addr;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_data;
    logic [31:0] i_wb_data;
    logic        i_wb_ack;

    wb_lsu_master #(.TIMEOUT(4)) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_we       (i_req_we),
        .i_req_addr     (i_req_addr),
        .i_req_size     (i_req_size),
        .i_req_unsigned (i_req_unsigned),
        .i_req_wdata    (i_req_wdata),
        .o_rsp_valid    (o_rsp_valid),
        .o_rsp_rdata    (o_rsp_rdata),
        .o_rsp_err      (o_rsp_err),
        .o_wb_cyc       (o_wb_cyc),
        .o_wb_stb       (o_wb_stb),
        .o_wb_we        (o_wb_we),
        .o_wb_addr      (o_wb_addr),
        .o_wb_sel       (o_wb_sel),
        .o_wb_data      (o_wb_data),
        .i_wb_data      (i_wb_data),
        .i_wb_ack       (i_wb_ack)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 0;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (mon_en) begin
            if (o_rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", o_rsp_valid, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_rdata", o_rsp_rdata, mon_e.rdata);
                    check("rsp_err", o_rsp_err, mon_e.err);
                end
            end else begin
                check("rsp_idle_zero", {o_rsp_rdata, o_rsp_err}, 0);
            end
            if (!o_wb_cyc) check("wb_idle_zero", {o_wb_stb, o_wb_we, o_wb_sel, o_wb_data}, 0);
        end
    end

    task automatic wait_ready(input string nm);
        int w = 0;
        while (!o_req_ready && w < 20) begin
            @(negedge i_clk);
            w++;
        end
        check({nm, ":ready"}, o_req_ready, 1);
    endtask

    // ack_dly = BUS cycles before the ack cycle; -1 = slave never acks.
    task automatic do_req(input string nm, input logic we, input logic [31:0] addr,
                          input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                          input int ack_dly, input logic [31:0] bus_rd,
                          input logic [3:0] x_sel, input logic [31:0] x_dat,
                          input logic [31:0] x_rdata, input logic x_err, input int x_cyc);
        int cyc_n = 0;
        int rsp_at = -1;
        logic [31:0] x_addr;
        rsp_t e;
        x_addr = {addr[31:2], 2'b00};
        wait_ready(nm);
        i_req_valid    = 1'b1;
        i_req_we       = we;
        i_req_addr     = addr;
        i_req_size     = size;
        i_req_unsigned = uns;
        i_req_wdata    = wdata;
        e.rdata = x_rdata;
        e.err   = x_err;
        exp_q.push_back(e);
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        for (int c = 0; c < 30 && rsp_at < 0; c++) begin
            @(negedge i_clk);
            i_wb_ack = 1'b0;
            if (o_wb_cyc) begin
                cyc_n++;
                check({nm, ":wb_ctl"}, {o_wb_stb, o_wb_we, o_wb_sel, o_wb_addr}, {1'b1, we, x_sel, x_addr});
                check({nm, ":wb_dat"}, o_wb_data, x_dat);
                if (cyc_n == ack_dly + 1) begin
                    i_wb_ack  = 1'b1;
                    i_wb_data = bus_rd;
                end
            end
            if (o_rsp_valid) rsp_at = c;
        end
        check({nm, ":rsp_seen"}, rsp_at >= 0, 1);
        check({nm, ":cyc_cycles"}, cyc_n, x_cyc);
        check({nm, ":rsp_latency"}, rsp_at, x_cyc);
        @(negedge i_clk);
        check({nm, ":pulse_one"}, o_rsp_valid, 0);
        check({nm, ":ready_back"}, o_req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int seen;
        i_rst = 1'b1;
        i_req_valid = 1'b0;
        i_req_we = 1'b0;
        i_req_addr = 32'd0;
        i_req_size = 2'b00;
        i_req_unsigned = 1'b0;
        i_req_wdata = 32'd0;
        i_wb_data = 32'd0;
        i_wb_ack = 1'b0;
        repeat (3) @(negedge i_clk);
        mon_en = 1;
        check("rst_ready", o_req_ready, 0);
        check("rst_cyc", o_wb_cyc, 0);
        check("rst_rsp", o_rsp_valid, 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rel_ready", o_req_ready, 1);

        //      name        we    addr          sz     uns   wdata          dly  bus_rd         sel      wb_dat         rdata          err   cyc
        do_req("ld_word",  1'b0, 32'h0000_0104, 2'b10, 1'b0, 32'h0,         2,  32'hDEAD_BEEF, 4'b1111, 32'h0,         32'hDEAD_BEEF, 1'b0, 3);
        do_req("ld_sb",    1'b0, 32'h0000_0103, 2'b00, 1'b0, 32'h0,         0,  32'h8012_3456, 4'b1000, 32'h0,         32'hFFFF_FF80, 1'b0, 1);
        do_req("ld_ub",    1'b0, 32'h0000_0103, 2'b00, 1'b1, 32'h0,         0,  32'h8012_3456, 4'b1000, 32'h0,         32'h0000_0080, 1'b0, 1);
        do_req("ld_sb_pos",1'b0, 32'h0000_0101, 2'b00, 1'b0, 32'h0,         1,  32'h0000_7F00, 4'b0010, 32'h0,         32'h0000_007F, 1'b0, 2);
        do_req("st_half",  1'b1, 32'h0000_0202, 2'b01, 1'b0, 32'hABCD_1234, 0,  32'h5555_5555, 4'b1100, 32'h1234_0000, 32'h0,         1'b0, 1);
        do_req("ld_sh",    1'b0, 32'h0000_0102, 2'b01, 1'b0, 32'h0,         1,  32'h8001_0000, 4'b1100, 32'h0,         32'hFFFF_8001, 1'b0, 2);
        do_req("ld_uh",    1'b0, 32'h0000_0100, 2'b01, 1'b1, 32'h0,         0,  32'h1234_F00D, 4'b0011, 32'h0,         32'h0000_F00D, 1'b0, 1);
        do_req("st_byte",  1'b1, 32'h0000_0401, 2'b00, 1'b0, 32'hFFFF_FFA5, 0,  32'h0,         4'b0010, 32'h0000_A500, 32'h0,         1'b0, 1);
        do_req("mis_word", 1'b0, 32'h0000_0101, 2'b10, 1'b0, 32'h0,         0,  32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 0);
        do_req("mis_half", 1'b0, 32'h0000_0103, 2'b01, 1'b0, 32'h0,         0,  32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 0);
        do_req("rsv_size", 1'b1, 32'h0000_0100, 2'b11, 1'b0, 32'h1,         0,  32'h0,         4'b0000, 32'h0,         32'h0,         1'b1, 0);
        do_req("timeout",  1'b0, 32'h0000_0300, 2'b10, 1'b0, 32'h0,        -1,  32'hFFFF_FFFF, 4'b1111, 32'h0,         32'h0,         1'b1, 4);

        // Reset lands in the second BUS cycle; the aborted request must not respond.
        wait_ready("rst_mid");
        i_req_valid = 1'b1;
        i_req_we = 1'b0;
        i_req_addr = 32'h0000_0600;
        i_req_size = 2'b10;
        i_req_unsigned = 1'b0;
        @(posedge i_clk);
        #1 i_req_valid = 1'b0;
        @(negedge i_clk);
        check("rst_mid:bus1", o_wb_cyc, 1);
        @(negedge i_clk);
        check("rst_mid:bus2", o_wb_cyc, 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        check("rst_mid:cyc_drop", o_wb_cyc, 0);
        check("rst_mid:ready_low", o_req_ready, 0);
        i_rst = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge i_clk);
            if (o_rsp_valid) seen++;
        end
        check("rst_mid:no_rsp", seen, 0);
        check("rst_mid:ready", o_req_ready, 1);

        do_req("st_word",  1'b1, 32'h0000_0500, 2'b10, 1'b0, 32'hCAFE_F00D, 1,  32'h0,         4'b1111, 32'hCAFE_F00D, 32'h0,         1'b0, 2);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
